// File: rtl/snn_spike_readout.sv
// snn_spike_readout: per-neuron spike counting over a frame, then a sequential argmax scan
// whose winner is offered on a valid/ready handshake.
module snn_spike_readout #(
    parameter  int N  = 96,
    parameter  int CW = 8,
    parameter  int TW = 16,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  spikes_vec,
    input  logic          spike_valid,
    input  logic          frame_start,
    input  logic          frame_end,
    output logic          busy,
    output logic          result_valid,
    input  logic          result_ready,
    output logic [IW-1:0] winner_idx,
    output logic [CW-1:0] winner_count,
    output logic [TW-1:0] total_spikes,
    output logic          no_spike,
    output logic          overrun,
    input  logic [IW-1:0] cnt_addr,
    output logic [CW-1:0] cnt_data
);
    localparam logic [IW:0] LN = (IW+1)'(N);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCAN, S_HOLD} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt [N];
    logic [CW-1:0] w_cnt_next [N];
    logic [TW-1:0] r_total;
    logic [TW:0]   w_pop, w_sum;
    logic [IW:0]   r_scan_i;
    logic [IW-1:0] r_best_idx, r_win_idx;
    logic [CW-1:0] r_best_cnt, r_win_cnt, r_cnt_data;
    logic          r_no_spike, r_overrun;
    logic          w_start, w_add, w_scan_done, w_blocked;

    assign w_start     = frame_start & (r_state == S_IDLE || r_state == S_ACCUM);
    assign w_add       = spike_valid & (r_state == S_ACCUM);
    assign w_scan_done = r_scan_i == LN;
    assign w_blocked   = (r_state == S_SCAN || r_state == S_HOLD) & (spike_valid | frame_start | frame_end);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = frame_start ? S_ACCUM : S_IDLE;
            S_ACCUM: w_next = (spike_valid && frame_end) ? S_SCAN : S_ACCUM;
            S_SCAN:  w_next = w_scan_done ? S_HOLD : S_SCAN;
            S_HOLD:  w_next = result_ready ? S_IDLE : S_HOLD;
            default: w_next = S_IDLE;
        endcase
    end

    // Clear takes priority over the add, so a restart with a row present loads that row.
    always_comb begin
        w_pop = '0;
        for (int n = 0; n < N; n++) begin
            w_pop = w_pop + {{TW{1'b0}}, spikes_vec[n]};
            w_cnt_next[n] = w_start ? {{(CW-1){1'b0}}, w_add & spikes_vec[n]} :
                            (w_add && spikes_vec[n] && r_cnt[n] != '1) ? r_cnt[n] + 1'b1 : r_cnt[n];
        end
        w_sum = {1'b0, w_start ? {TW{1'b0}} : r_total} + (w_add ? w_pop : '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '{default: '0};
            r_total    <= '0;
            r_scan_i   <= '0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
            r_win_idx  <= '0;
            r_win_cnt  <= '0;
            r_no_spike <= 1'b0;
            r_overrun  <= 1'b0;
            r_cnt_data <= '0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_total    <= w_sum[TW] ? '1 : w_sum[TW-1:0];
            r_cnt_data <= ({1'b0, cnt_addr} < LN) ? r_cnt[cnt_addr] : '0;
            if (w_start)
                r_overrun <= 1'b0;
            else if (w_blocked)
                r_overrun <= 1'b1;
            // One neuron per cycle; strict compare keeps the lowest index on ties.
            if (r_state != S_SCAN) begin
                r_scan_i   <= '0;
                r_best_idx <= '0;
                r_best_cnt <= '0;
            end else if (!w_scan_done) begin
                if (r_cnt[r_scan_i[IW-1:0]] > r_best_cnt) begin
                    r_best_cnt <= r_cnt[r_scan_i[IW-1:0]];
                    r_best_idx <= r_scan_i[IW-1:0];
                end
                r_scan_i <= r_scan_i + 1'b1;
            end else begin
                r_win_idx  <= r_best_idx;
                r_win_cnt  <= r_best_cnt;
                r_no_spike <= r_best_cnt == '0;
            end
        end
    end

    assign busy         = r_state != S_IDLE;
    assign result_valid = r_state == S_HOLD;
    assign winner_idx   = r_win_idx;
    assign winner_count = r_win_cnt;
    assign total_spikes = r_total;
    assign no_spike     = r_no_spike;
    assign overrun      = r_overrun;
    assign cnt_data     = r_cnt_data;
endmodule

// File: tb/tb_snn_spike_readout.sv
// tb_snn_spike_readout: directed and randomized frames checked against a count/argmax model.
module tb_snn_spike_readout;
    localparam int N  = 96;
    localparam int CW = 8;
    localparam int TW = 16;
    localparam int IW = $clog2(N);
    localparam int CMAX = (1 << CW) - 1;
    localparam int TMAX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [N-1:0]  spikes_vec = '0;
    logic          spike_valid = 1'b0;
    logic          frame_start = 1'b0;
    logic          frame_end = 1'b0;
    logic          result_ready = 1'b0;
    logic [IW-1:0] cnt_addr = '0;
    logic          busy, result_valid, no_spike, overrun;
    logic [IW-1:0] winner_idx;
    logic [CW-1:0] winner_count, cnt_data;
    logic [TW-1:0] total_spikes;

    int m_cnt [N];
    int m_total;
    int n_checks = 0;
    int n_pass = 0;

    snn_spike_readout #(.N(N), .CW(CW), .TW(TW)) dut (
        .clk(clk), .rstn(rstn), .spikes_vec(spikes_vec), .spike_valid(spike_valid),
        .frame_start(frame_start), .frame_end(frame_end), .busy(busy),
        .result_valid(result_valid), .result_ready(result_ready), .winner_idx(winner_idx),
        .winner_count(winner_count), .total_spikes(total_spikes), .no_spike(no_spike),
        .overrun(overrun), .cnt_addr(cnt_addr), .cnt_data(cnt_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_total = 0;
    endtask

    task automatic model_add(input logic [N-1:0] row);
        for (int i = 0; i < N; i++)
            if (row[i]) m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
        m_total = (m_total + $countones(row) > TMAX) ? TMAX : m_total + $countones(row);
    endtask

    function automatic int best_idx();
        int b = 0;
        for (int i = 1; i < N; i++) if (m_cnt[i] > m_cnt[b]) b = i;
        return b;
    endfunction

    function automatic logic [N-1:0] rnd_row();
        logic [N-1:0] a, b;
        a = {$urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom};
        return a & b;
    endfunction

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        model_clear();
    endtask

    task automatic step(input logic [N-1:0] row, input bit fe);
        spikes_vec = row;
        spike_valid = 1'b1;
        frame_end = fe;
        tick();
        spike_valid = 1'b0;
        frame_end = 1'b0;
        spikes_vec = '0;
        model_add(row);
    endtask

    // Called just after the frame_end edge: measures edges until result_valid.
    task automatic expect_result(input string tag);
        int e = 0;
        int b;
        b = best_idx();
        while (!result_valid && e < 400) begin
            tick();
            e++;
        end
        check({tag, ".latency"}, e, N + 1);
        check({tag, ".idx"}, winner_idx, b);
        check({tag, ".count"}, winner_count, m_cnt[b]);
        check({tag, ".total"}, total_spikes, m_total);
        check({tag, ".no_spike"}, no_spike, m_cnt[b] == 0);
        check({tag, ".busy"}, busy, 1);
    endtask

    task automatic accept(input string tag);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check({tag, ".idle"}, {result_valid, busy}, 0);
    endtask

    task automatic readback(input string tag, input int a);
        cnt_addr = IW'(a);
        tick();
        check({tag, ".cnt_data"}, cnt_data, m_cnt[a]);
    endtask

    initial begin
        logic [N-1:0] r;
        int len;
        model_clear();
        repeat (3) tick();
        check("rst.outputs", {busy, result_valid, no_spike, overrun}, 0);
        check("rst.winner", {winner_idx, winner_count}, 0);
        check("rst.total", total_spikes, 0);
        check("rst.cnt_data", cnt_data, 0);
        rstn = 1'b1;
        tick();

        // T1: single neuron spiking three times
        start_frame();
        r = '0; r[5] = 1'b1;
        step(r, 0); step(r, 0); step(r, 1);
        expect_result("t1");
        check("t1.overrun", overrun, 0);
        accept("t1");
        readback("t1", 5);

        // T2: tie between neurons 7 and 2
        start_frame();
        r = '0; r[7] = 1'b1; r[2] = 1'b1;
        for (int i = 0; i < 4; i++) step(r, i == 3);
        expect_result("t2");
        accept("t2");

        // T3: empty frame
        start_frame();
        for (int i = 0; i < 10; i++) step('0, i == 9);
        expect_result("t3");
        accept("t3");

        // Restart in ACCUM, lone frame_end ignored, spike_valid in IDLE ignored
        spikes_vec = rnd_row(); spike_valid = 1'b1; tick(); spike_valid = 1'b0;
        readback("idle_ignore", 0);
        start_frame();
        step(rnd_row(), 0);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        check("lone_fe.busy", {busy, result_valid}, 2'b10);
        r = rnd_row();
        spikes_vec = r; spike_valid = 1'b1; frame_start = 1'b1;
        tick();
        spike_valid = 1'b0; frame_start = 1'b0;
        model_clear(); model_add(r);
        step(rnd_row(), 1);
        expect_result("restart");
        accept("restart");

        // T4: counter and total saturation
        start_frame();
        r = '0; r[0] = 1'b1;
        for (int i = 0; i < 300; i++) step(r, 0);
        for (int i = 0; i < 700; i++) step('1, i == 699);
        expect_result("t4");
        accept("t4");
        readback("t4", 50);

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            start_frame();
            len = $urandom_range(1, 25);
            for (int i = 0; i < len; i++) step(rnd_row(), i == len - 1);
            expect_result("rand");
            accept("rand");
            readback("rand", $urandom_range(0, N - 1));
        end

        // T5: stalled result with traffic -> stable outputs, sticky overrun
        start_frame();
        for (int i = 0; i < 8; i++) step(rnd_row(), i == 7);
        expect_result("t5");
        for (int i = 0; i < 20; i++) begin
            spikes_vec = rnd_row();
            spike_valid = i[0];
            frame_start = (i == 9);
            frame_end = (i == 13);
            tick();
        end
        spike_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0; spikes_vec = '0;
        check("t5.valid", result_valid, 1);
        check("t5.idx", winner_idx, best_idx());
        check("t5.count", winner_count, m_cnt[best_idx()]);
        check("t5.total", total_spikes, m_total);
        check("t5.overrun", overrun, 1);
        accept("t5");
        check("t5.overrun_idle", overrun, 1);
        start_frame();
        check("t5.overrun_clr", overrun, 0);
        step(rnd_row(), 1);
        expect_result("t5b");
        accept("t5b");

        // T6: asynchronous reset in the middle of a scan
        start_frame();
        for (int i = 0; i < 5; i++) step(rnd_row(), i == 4);
        repeat (10) tick();
        check("t6.busy_pre", busy, 1);
        #2 rstn = 1'b0;
        #1;
        check("t6.outputs", {busy, result_valid, no_spike, overrun}, 0);
        check("t6.winner", {winner_idx, winner_count}, 0);
        check("t6.total", total_spikes, 0);
        check("t6.cnt_data", cnt_data, 0);
        @(negedge clk) rstn = 1'b1;
        model_clear();
        tick();
        start_frame();
        for (int i = 0; i < 6; i++) step(rnd_row(), i == 5);
        expect_result("t6b");
        accept("t6b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
